// File: rtl/regbank_pkg.sv
// Shared constants and the round-robin search used by the register-file write arbiter.
package regbank_pkg;

    localparam int REG_AW  = 5;
    localparam int REG_DW  = 32;
    localparam int REG_NUM = 32;

    // Widest requester count the search function supports.
    localparam int RR_MAX = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_result_t;

    // Scan ptr, ptr+1, ... modulo n and return the first set request bit.
    function automatic rr_result_t rr_search(
        input logic [RR_MAX-1:0] req,
        input logic [2:0]        ptr,
        input int unsigned       n
    );
        rr_result_t  res;
        int unsigned k;
        res = '0;
        for (int unsigned i = 0; i < RR_MAX; i++) begin
            k = (32'(ptr) + i) % n;
            if (!res.found && (i < n) && req[k[2:0]]) begin
                res.found = 1'b1;
                res.idx   = k[2:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr wins.
module rr_arbiter
    import regbank_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_idx,
    output logic                    any
);

    localparam int IW = $clog2(NREQ);

    logic [RR_MAX-1:0] req_ext;
    logic [2:0]        ptr_ext;
    rr_result_t        res;

    always_comb begin
        req_ext           = '0;
        req_ext[NREQ-1:0] = req;
        ptr_ext           = '0;
        ptr_ext[IW-1:0]   = ptr;
        res               = rr_search(req_ext, ptr_ext, NREQ);
        gnt_idx           = res.idx[IW-1:0];
        // The range test is always true for a found index; it keeps the full index in use.
        any               = res.found && (32'(res.idx) < NREQ);
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt
        assign gnt[gi] = any && (gnt_idx == IW'(gi));
    end

endmodule

// File: rtl/regbank_wr_arbiter.sv
// Shares the register-file write port among NREQ requesters, each with a one-entry
// holding buffer, drained round-robin onto a registered write/dr/wrData stage.
module regbank_wr_arbiter
    import regbank_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = REG_AW,
    parameter int DW   = REG_DW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*AW-1:0]      req_addr,
    input  logic [NREQ*DW-1:0]      req_data,
    output logic                    write,
    output logic [AW-1:0]           dr,
    output logic [DW-1:0]           wrData,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic [2**AW-1:0]        pend
);

    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0] ready_reg;
    logic [NREQ-1:0] ready_next;
    logic [NREQ-1:0] buf_full;
    logic [AW-1:0]   buf_addr_reg [NREQ];
    logic [DW-1:0]   buf_data_reg [NREQ];
    logic [NREQ-1:0] capture;

    logic [IW-1:0]   ptr_reg;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_any;

    logic            write_reg;
    logic [AW-1:0]   dr_reg;
    logic [DW-1:0]   wr_data_reg;
    logic [IW-1:0]   grant_id_reg;

    // Ready is held in its own flop so it never depends on valid or the grant.
    assign buf_full  = ~ready_reg;
    assign req_ready = ready_reg;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_buf
        assign capture[gi] = req_valid[gi] & ready_reg[gi];
    end

    // Capture needs an empty buffer and grant needs a full one, so they never collide.
    always_comb begin
        ready_next = ready_reg;
        for (int i = 0; i < NREQ; i++) begin
            if (capture[i]) begin
                ready_next[i] = 1'b0;
            end else if (gnt[i]) begin
                ready_next[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_reg <= '1;
        end else begin
            ready_reg <= ready_next;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (capture[i]) begin
                buf_addr_reg[i] <= req_addr[i*AW +: AW];
                buf_data_reg[i] <= req_data[i*DW +: DW];
            end
        end
    end

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .req     (buf_full),
        .ptr     (ptr_reg),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_reg      <= '0;
            write_reg    <= 1'b0;
            dr_reg       <= '0;
            wr_data_reg  <= '0;
            grant_id_reg <= '0;
        end else if (gnt_any) begin
            ptr_reg      <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
            write_reg    <= 1'b1;
            dr_reg       <= buf_addr_reg[gnt_idx];
            wr_data_reg  <= buf_data_reg[gnt_idx];
            grant_id_reg <= gnt_idx;
        end else begin
            write_reg    <= 1'b0;
        end
    end

    assign write    = write_reg;
    assign dr       = dr_reg;
    assign wrData   = wr_data_reg;
    assign grant_id = grant_id_reg;

    // Anything buffered or sitting on the output stage is not yet in the register file.
    always_comb begin
        pend = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (buf_full[i]) begin
                pend[buf_addr_reg[i]] = 1'b1;
            end
        end
        if (write_reg) begin
            pend[dr_reg] = 1'b1;
        end
    end

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Directed bench: stimulus pushes expected commits into a queue, a monitor pops and checks them.
module tb_regbank_wr_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic                 write;
    logic [AW-1:0]        dr;
    logic [DW-1:0]        wrData;
    logic [1:0]           grant_id;
    logic [2**AW-1:0]     pend;

    typedef struct packed {
        logic [AW-1:0] dr;
        logic [DW-1:0] data;
        logic [1:0]    gid;
    } txn_t;

    txn_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    regbank_wr_arbiter #(
        .NREQ (NREQ),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .write     (write),
        .dr        (dr),
        .wrData    (wrData),
        .grant_id  (grant_id),
        .pend      (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every cycle with write=1 must match the oldest expected commit.
    always @(negedge clk) begin
        if (write === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write dr=%0d data=%h gid=%0d (no write required)",
                         dr, wrData, grant_id);
            end else begin
                txn_t e;
                e = exp_q.pop_front();
                if (dr !== e.dr || wrData !== e.data || grant_id !== e.gid) begin
                    bad++;
                    $display("FAIL commit got dr=%0d data=%h gid=%0d want dr=%0d data=%h gid=%0d",
                             dr, wrData, grant_id, e.dr, e.data, e.gid);
                end else begin
                    $display("txn ok dr=%0d data=%h gid=%0d", dr, wrData, grant_id);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, req);
        end
    endtask

    task automatic drive(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]        = 1'b1;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic expect_txn(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] g);
        txn_t t;
        t.dr   = a;
        t.data = d;
        t.gid  = g;
        exp_q.push_back(t);
    endtask

    // Lone request from requester i, fully drained afterwards.
    task automatic single(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        drive(i, a, d);
        expect_txn(a, d, 2'(i));
        step();
        req_valid = '0;
        step();
        step();
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_addr  = '0;
        req_data  = '0;

        // Reset with valid requests present: nothing gets buffered or committed.
        step();
        step();
        rst_n     = 1'b1;
        req_valid = '0;
        step();
        check("rst_write", 64'(write), 64'h0);
        check("rst_pend", 64'(pend), 64'h0);
        check("rst_ready", 64'(req_ready), 64'hF);
        check("rst_dr_data_gid", {dr, wrData, grant_id}, 64'h0);

        // Single request from requester 2.
        drive(2, 5'd5, 32'hDEADBEEF);
        expect_txn(5'd5, 32'hDEADBEEF, 2'd2);
        step();
        req_valid = '0;
        check("single_ready_low", 64'(req_ready), 64'hB);
        check("single_pend_buf", 64'(pend), 64'h20);
        step();
        check("single_write", 64'(write), 64'h1);
        check("single_pend_out", 64'(pend), 64'h20);
        step();
        check("single_pend_clear", 64'(pend), 64'h0);
        check("single_ready_back", 64'(req_ready), 64'hF);

        // Burst from all four with ptr=0.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            drive(i, 5'(10 + i), 32'hA0 + 32'(i));
            expect_txn(5'(10 + i), 32'hA0 + 32'(i), 2'(i));
        end
        step();
        req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("burst0_write", 64'(write), 64'h1);
        end
        step();
        check("burst0_idle", 64'(write), 64'h0);

        // Move ptr to 1, then a second burst is served 1,2,3,0.
        single(0, 5'd1, 32'h100);
        for (int i = 0; i < NREQ; i++) begin
            drive(i, 5'(20 + i), 32'hB0 + 32'(i));
        end
        expect_txn(5'd21, 32'hB1, 2'd1);
        expect_txn(5'd22, 32'hB2, 2'd2);
        expect_txn(5'd23, 32'hB3, 2'd3);
        expect_txn(5'd20, 32'hB0, 2'd0);
        step();
        req_valid = '0;
        for (int k = 0; k < 5; k++) step();
        check("burst1_idle", 64'(write), 64'h0);

        // ptr currently 1; lone grant of 1 moves it to 2, then the same-address race.
        single(1, 5'd2, 32'h22);
        drive(1, 5'd7, 32'h1);
        drive(3, 5'd7, 32'h3);
        expect_txn(5'd7, 32'h3, 2'd3);
        expect_txn(5'd7, 32'h1, 2'd1);
        step();
        req_valid = '0;
        check("race_pend_buf", 64'(pend[7]), 64'h1);
        step();
        check("race_pend_out1", 64'(pend[7]), 64'h1);
        step();
        check("race_pend_out2", 64'(pend[7]), 64'h1);
        step();
        check("race_pend_clear", 64'(pend), 64'h0);

        // Requester 0 holds valid; only payloads at even offsets are accepted.
        for (int k = 0; k < 4; k++) begin
            expect_txn(5'(2 * k), 32'h500 + 32'(2 * k), 2'd0);
        end
        drive(0, 5'd0, 32'h500);
        for (int j = 0; j < 8; j++) begin
            step();
            check("b2b_write", 64'(write), 64'(j % 2));
            check("b2b_ready", 64'(req_ready[0]), 64'(j % 2));
            drive(0, 5'(j + 1), 32'h500 + 32'(j + 1));
        end
        req_valid = '0;
        step();
        check("b2b_idle", 64'(write), 64'h0);
        step();

        // ptr=1; grant 3 alone returns it to 0, then reset lands on buffer 0's grant edge.
        single(3, 5'd3, 32'h33);
        drive(0, 5'd8, 32'hC0);
        drive(1, 5'd9, 32'hC1);
        step();
        req_valid = '0;
        check("midrst_pend_buf", 64'(pend), 64'h300);
        rst_n = 1'b0;
        step();
        check("midrst_write", 64'(write), 64'h0);
        check("midrst_pend", 64'(pend), 64'h0);
        check("midrst_ready", 64'(req_ready), 64'hF);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) step();
        check("midrst_quiet", 64'(write), 64'h0);
        check("midrst_pend_after", 64'(pend), 64'h0);

        check("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
